// File: rtl/mvm_ctrl_pkg.sv
// ============================================================================
//  Package     : mvm_ctrl_pkg
//  Description : Shared types and helpers for the MVM UART frame controller.
//                Holds the FSM state type, the frame-width calculations and a
//                sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mvm_ctrl_pkg;

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_Y = 2'd2,
    SEND   = 2'd3
  } state_t;

  function automatic int k_bits(input int r, input int c, input int wk);
    return r * c * wk;
  endfunction

  function automatic int x_bits(input int c, input int wx);
    return c * wx;
  endfunction

  // Number of UART words needed to carry K followed by X (rounded up).
  function automatic int rx_words(input int kb, input int xb, input int bpw);
    return (kb + xb + bpw - 1) / bpw;
  endfunction

  // Sign-extends the low w bits of v to 32 bits (1 <= w <= 32).
  function automatic logic [31:0] sign_extend(input logic [31:0] v, input int w);
    logic [31:0] hi;
    logic        sgn;
    hi  = (w >= 32) ? 32'h0 : (32'hFFFF_FFFF << w);
    sgn = v[5'(w - 1)];
    return sgn ? (v | hi) : (v & ~hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mvm_uart_frame_ctrl_if.sv
// ============================================================================
//  Interface   : mvm_uart_frame_ctrl_if
//  Description : Handshake bundle around the frame controller.
//                rx_*  : UART RX byte stream into the controller
//                mvm_* : K/X operands towards the MVM engine
//                y_*   : result from the MVM engine
//                tx_*  : UART TX byte stream out of the controller
//                master = controller side, slave = surrounding system.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mvm_uart_frame_ctrl_if #(
  parameter int BITS_PER_WORD = 8,
  parameter int R             = 2,
  parameter int C             = 2,
  parameter int W_X           = 4,
  parameter int W_K           = 2,
  parameter int W_Y_OUT       = 8
);
  logic                     rx_valid;
  logic [BITS_PER_WORD-1:0] rx_data;
  logic                     rx_ready;

  logic [R*C*W_K-1:0]       mvm_k;
  logic [C*W_X-1:0]         mvm_x;
  logic                     mvm_valid;
  logic                     mvm_ready;

  logic                     y_valid;
  logic [R*W_Y_OUT-1:0]     y_data;
  logic                     y_ready;

  logic                     tx_valid;
  logic [BITS_PER_WORD-1:0] tx_data;
  logic                     tx_ready;

  modport master (
    input  rx_valid, rx_data, mvm_ready, y_valid, y_data, tx_ready,
    output rx_ready, mvm_k, mvm_x, mvm_valid, y_ready, tx_valid, tx_data
  );

  modport slave (
    output rx_valid, rx_data, mvm_ready, y_valid, y_data, tx_ready,
    input  rx_ready, mvm_k, mvm_x, mvm_valid, y_ready, tx_valid, tx_data
  );
endinterface

`default_nettype wire

// File: rtl/mvm_rx_assembler.sv
// ============================================================================
//  Module      : mvm_rx_assembler
//  Description : Collects UART bytes into a little-endian frame buffer and
//                drops partial frames after an inter-byte timeout.
//  Ports       : clk, rst            clock / async active-high reset
//                i_rx_valid/i_rx_data/i_rx_ready  RX handshake (ready from top)
//                i_recv              controller is in the receive state
//                i_clear             discard the held frame (frame finished)
//                o_frame_done        final byte of a frame transfers this cycle
//                o_frame_bits        buffer including the byte transferring now
//                o_timeout_pulse     registered 1-cycle pulse on frame drop
//                o_empty_next        byte count will be zero after this edge
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvm_rx_assembler
  import mvm_ctrl_pkg::*;
#(
  parameter int BITS_PER_WORD  = 8,
  parameter int K_BITS         = 8,
  parameter int X_BITS         = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_rx_valid,
  input  wire logic [BITS_PER_WORD-1:0] i_rx_data,
  input  wire logic                     i_rx_ready,
  input  wire logic                     i_recv,
  input  wire logic                     i_clear,
  output logic                          o_frame_done,
  output logic [rx_words(K_BITS, X_BITS, BITS_PER_WORD)*BITS_PER_WORD-1:0] o_frame_bits,
  output logic                          o_timeout_pulse,
  output logic                          o_empty_next
);
  localparam int RX_WORDS = rx_words(K_BITS, X_BITS, BITS_PER_WORD);
  localparam int BUF_BITS = RX_WORDS * BITS_PER_WORD;
  localparam int CW       = $clog2(RX_WORDS + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] c_last_byte = CW'(RX_WORDS - 1);
  // Expiry is flagged while the counter sits one below TIMEOUT_CYCLES-1, so
  // the drop lands on the edge where it would have reached TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] c_to_last   = TW'(TIMEOUT_CYCLES - 2);

  logic [BUF_BITS-1:0] r_buf, w_buf_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic [TW-1:0]       r_tcnt, w_tcnt_next;
  logic                r_timeout;
  logic                w_fire, w_expire;

  assign w_fire   = i_rx_valid & i_rx_ready & i_recv;
  // A byte arriving on the expiry cycle takes priority over the drop.
  assign w_expire = i_recv & (r_cnt != '0) & ~w_fire & (r_tcnt == c_to_last);

  always_comb begin
    w_buf_next = r_buf;
    for (int n = 0; n < RX_WORDS; n++) begin
      if (w_fire && (r_cnt == CW'(n))) begin
        w_buf_next[n*BITS_PER_WORD +: BITS_PER_WORD] = i_rx_data;
      end
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear)       w_cnt_next = '0;
    else if (w_fire)   w_cnt_next = r_cnt + CW'(1);
    else if (w_expire) w_cnt_next = '0;
  end

  always_comb begin
    w_tcnt_next = r_tcnt + TW'(1);
    if (w_fire || !i_recv || (r_cnt == '0) || w_expire) w_tcnt_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf     <= '0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_buf     <= w_buf_next;
      r_cnt     <= w_cnt_next;
      r_tcnt    <= w_tcnt_next;
      r_timeout <= w_expire;
    end
  end

  assign o_frame_done    = w_fire & (r_cnt == c_last_byte);
  assign o_frame_bits    = w_buf_next;
  assign o_timeout_pulse = r_timeout;
  assign o_empty_next    = (w_cnt_next == '0);

endmodule

`default_nettype wire

// File: rtl/mvm_uart_frame_ctrl.sv
// ============================================================================
//  Module      : mvm_uart_frame_ctrl
//  Description : Frame sequencer between UART byte streams and the MVM engine.
//                Receives one K/X frame, issues it, waits for Y and sends the
//                Y elements (row 0 first, sign-extended) on the UART TX.
//  Ports       : clk, rst     clock / async active-high reset
//                bus          mvm_uart_frame_ctrl_if.master (RX, MVM, Y, TX)
//                busy         high unless idle in RECV with no bytes held
//                err_timeout  1-cycle pulse when a partial frame is dropped
//                frame_count  completed frames, wraps 255 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvm_uart_frame_ctrl
  import mvm_ctrl_pkg::*;
#(
  parameter int BITS_PER_WORD  = 8,
  parameter int R              = 2,
  parameter int C              = 2,
  parameter int W_X            = 4,
  parameter int W_K            = 2,
  parameter int W_Y_OUT        = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic              clk,
  input  wire logic              rst,
  mvm_uart_frame_ctrl_if.master  bus,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [7:0]             frame_count
);
  localparam int K_BITS   = k_bits(R, C, W_K);
  localparam int X_BITS   = x_bits(C, W_X);
  localparam int RX_WORDS = rx_words(K_BITS, X_BITS, BITS_PER_WORD);
  localparam int BUF_BITS = RX_WORDS * BITS_PER_WORD;
  localparam int IW       = (R > 1) ? $clog2(R) : 1;

  localparam logic [IW-1:0] c_last_idx = IW'(R - 1);

  state_t                   r_state, w_state_next;
  logic                     r_rx_ready, r_mvm_valid, r_y_ready, r_tx_valid, r_busy;
  logic [K_BITS-1:0]        r_k;
  logic [X_BITS-1:0]        r_x;
  logic [R*W_Y_OUT-1:0]     r_y;
  logic [BITS_PER_WORD-1:0] r_tx_data;
  logic [IW-1:0]            r_idx;
  logic [7:0]               r_frame_count;

  logic                     w_frame_done, w_timeout, w_empty_next;
  logic [BUF_BITS-1:0]      w_frame_bits;
  logic                     w_mvm_fire, w_y_fire, w_tx_fire, w_tx_last;
  logic [IW-1:0]            w_idx_next;
  logic [BITS_PER_WORD-1:0] w_y_ext [R];
  logic [BITS_PER_WORD-1:0] w_y_in0;

  mvm_rx_assembler #(
    .BITS_PER_WORD  (BITS_PER_WORD),
    .K_BITS         (K_BITS),
    .X_BITS         (X_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk             (clk),
    .rst             (rst),
    .i_rx_valid      (bus.rx_valid),
    .i_rx_data       (bus.rx_data),
    .i_rx_ready      (r_rx_ready),
    .i_recv          (r_state == RECV),
    .i_clear         (w_tx_last),
    .o_frame_done    (w_frame_done),
    .o_frame_bits    (w_frame_bits),
    .o_timeout_pulse (w_timeout),
    .o_empty_next    (w_empty_next)
  );

  assign w_mvm_fire = r_mvm_valid & bus.mvm_ready;
  assign w_y_fire   = bus.y_valid & r_y_ready;
  assign w_tx_fire  = r_tx_valid & bus.tx_ready;
  assign w_tx_last  = w_tx_fire & (r_idx == c_last_idx);
  assign w_idx_next = r_idx + IW'(1);

  // Sign-extended view of every held Y element, plus element 0 of the
  // incoming result so the first TX byte is ready the cycle SEND starts.
  for (genvar gi = 0; gi < R; gi++) begin : g_yext
    assign w_y_ext[gi] = BITS_PER_WORD'(sign_extend(32'(r_y[gi*W_Y_OUT +: W_Y_OUT]), W_Y_OUT));
  end
  assign w_y_in0 = BITS_PER_WORD'(sign_extend(32'(bus.y_data[W_Y_OUT-1:0]), W_Y_OUT));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RECV:    if (w_frame_done) w_state_next = ISSUE;
      ISSUE:   if (w_mvm_fire)   w_state_next = WAIT_Y;
      WAIT_Y:  if (w_y_fire)     w_state_next = SEND;
      SEND:    if (w_tx_last)    w_state_next = RECV;
      default:                   w_state_next = RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RECV;
    else     r_state <= w_state_next;
  end

  // Handshake outputs are registered from the next state so they line up
  // with the state register without any input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ready    <= 1'b0;
      r_mvm_valid   <= 1'b0;
      r_y_ready     <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_k           <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_tx_data     <= '0;
      r_idx         <= '0;
      r_frame_count <= '0;
    end else begin
      r_rx_ready  <= (w_state_next == RECV);
      r_mvm_valid <= (w_state_next == ISSUE);
      r_y_ready   <= (w_state_next == WAIT_Y);
      r_tx_valid  <= (w_state_next == SEND);
      r_busy      <= !((w_state_next == RECV) && w_empty_next);
      if (w_frame_done) begin
        r_k <= w_frame_bits[K_BITS-1:0];
        r_x <= w_frame_bits[K_BITS +: X_BITS];
      end
      if (w_y_fire) begin
        r_y       <= bus.y_data;
        r_tx_data <= w_y_in0;
        r_idx     <= '0;
      end else if (w_tx_fire) begin
        if (w_tx_last) begin
          r_idx         <= '0;
          r_frame_count <= r_frame_count + 8'd1;
        end else begin
          r_idx     <= w_idx_next;
          r_tx_data <= w_y_ext[w_idx_next];
        end
      end
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.mvm_valid = r_mvm_valid;
  assign bus.mvm_k     = r_k;
  assign bus.mvm_x     = r_x;
  assign bus.y_ready   = r_y_ready;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_tx_data;
  assign busy          = r_busy;
  assign err_timeout   = w_timeout;
  assign frame_count   = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_mvm_uart_frame_ctrl.sv
// ============================================================================
//  Module      : tb_mvm_uart_frame_ctrl
//  Description : Self-checking bench for mvm_uart_frame_ctrl. Two instances
//                share stimulus: dut_a with 8-bit Y elements and dut_b with
//                6-bit Y elements, both with a short inter-byte timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvm_uart_frame_ctrl;
  localparam int BPW  = 8;
  localparam int R    = 2;
  localparam int C    = 2;
  localparam int W_X  = 4;
  localparam int W_K  = 2;
  localparam int W_Y  = 8;
  localparam int W_YB = 6;
  localparam int TO   = 16;
  localparam int KB   = R * C * W_K;
  localparam int XB   = C * W_X;
  localparam int RXW  = (KB + XB + BPW - 1) / BPW;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy_a, err_a, busy_b, err_b;
  logic [7:0] fc_a, fc_b;

  always #5 clk = ~clk;

  mvm_uart_frame_ctrl_if #(.BITS_PER_WORD(BPW), .R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y_OUT(W_Y))  ifa ();
  mvm_uart_frame_ctrl_if #(.BITS_PER_WORD(BPW), .R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y_OUT(W_YB)) ifb ();

  assign ifb.rx_valid  = ifa.rx_valid;
  assign ifb.rx_data   = ifa.rx_data;
  assign ifb.mvm_ready = ifa.mvm_ready;
  assign ifb.y_valid   = ifa.y_valid;
  assign ifb.tx_ready  = ifa.tx_ready;
  assign ifb.y_data    = {ifa.y_data[W_Y +: W_YB], ifa.y_data[0 +: W_YB]};

  mvm_uart_frame_ctrl #(.BITS_PER_WORD(BPW), .R(R), .C(C), .W_X(W_X), .W_K(W_K),
                        .W_Y_OUT(W_Y), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .err_timeout(err_a), .frame_count(fc_a));

  mvm_uart_frame_ctrl #(.BITS_PER_WORD(BPW), .R(R), .C(C), .W_X(W_X), .W_K(W_K),
                        .W_Y_OUT(W_YB), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .err_timeout(err_b), .frame_count(fc_b));

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int          m_cnt;
  logic [7:0]  m_bytes [RXW];
  int          m_fc;
  logic [15:0] m_y;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int w);
    int r;
    r = v;
    if (r >= (1 << (w - 1))) r = r - (1 << w);
    return r & ((1 << BPW) - 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.rx_valid = 1'b0; ifa.mvm_ready = 1'b0; ifa.y_valid = 1'b0; ifa.tx_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_rx_ready", ifa.rx_ready, 0);
    chk("rst_mvm_valid", ifa.mvm_valid, 0);
    chk("rst_y_ready", ifa.y_ready, 0);
    chk("rst_tx_valid", ifa.tx_valid, 0);
    chk("rst_tx_data", ifa.tx_data, 0);
    chk("rst_mvm_k", ifa.mvm_k, 0);
    chk("rst_mvm_x", ifa.mvm_x, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fc", fc_a, 0);
    chk("rst_b_tx_valid", ifb.tx_valid, 0);
    chk("rst_b_tx_data", ifb.tx_data, 0);
    chk("rst_b_fc", fc_b, 0);
    rst = 1'b0;
    m_cnt = 0;
    m_fc  = 0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_rx_ready", ifa.rx_ready, 1);
    chk("post_rst_busy", busy_a, 0);
  endtask

  // Idle for gap cycles, then transfer one byte. Called at a negedge in RECV.
  task automatic rx_byte(input logic [7:0] b, input int gap);
    logic exp_err;
    for (int i = 1; i <= gap; i++) begin
      @(posedge clk); @(negedge clk);
      exp_err = (m_cnt > 0) && (i == TO - 1);
      chk("err_timeout", err_a, exp_err);
      chk("err_timeout_b", err_b, exp_err);
      if (exp_err) m_cnt = 0;
      chk("busy_gap", busy_a, m_cnt > 0);
    end
    chk("rx_ready", ifa.rx_ready, 1);
    ifa.rx_valid = 1'b1;
    ifa.rx_data  = b;
    @(posedge clk); @(negedge clk);
    ifa.rx_valid = 1'b0;
    m_bytes[m_cnt] = b;
    m_cnt++;
    chk("err_after_byte", err_a, 0);
    chk("busy_after_byte", busy_a, 1);
  endtask

  task automatic issue_phase(input int stall);
    int f, ek, ex;
    f = 0;
    for (int n = 0; n < RXW; n++) f += int'(m_bytes[n]) << (BPW * n);
    ek = f & ((1 << KB) - 1);
    ex = (f >> KB) & ((1 << XB) - 1);
    chk("mvm_valid", ifa.mvm_valid, 1);
    chk("mvm_k", ifa.mvm_k, ek);
    chk("mvm_x", ifa.mvm_x, ex);
    chk("rx_ready_issue", ifa.rx_ready, 0);
    // Upstream holds a byte pending; it must not be taken outside RECV.
    ifa.rx_valid = 1'b1;
    ifa.rx_data  = 8'($urandom);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      chk("mvm_valid_hold", ifa.mvm_valid, 1);
      chk("mvm_k_hold", ifa.mvm_k, ek);
      chk("mvm_x_hold", ifa.mvm_x, ex);
      chk("rx_ready_hold", ifa.rx_ready, 0);
    end
    ifa.mvm_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ifa.mvm_ready = 1'b0;
    chk("mvm_valid_drop", ifa.mvm_valid, 0);
    chk("y_ready", ifa.y_ready, 1);
    chk("rx_ready_wait", ifa.rx_ready, 0);
  endtask

  task automatic y_phase(input int dly, input logic [15:0] y);
    for (int d = 0; d < dly; d++) begin
      @(posedge clk); @(negedge clk);
      chk("y_ready_hold", ifa.y_ready, 1);
      chk("tx_valid_wait", ifa.tx_valid, 0);
    end
    ifa.y_valid = 1'b1;
    ifa.y_data  = y;
    m_y = y;
    @(posedge clk); @(negedge clk);
    ifa.y_valid  = 1'b0;
    ifa.rx_valid = 1'b0;
    chk("y_ready_drop", ifa.y_ready, 0);
  endtask

  // stall0 < 0 selects random stalls for the first element too.
  task automatic tx_phase(input int stall0, input int stop_after);
    int ea, eb, st, elem;
    for (int r = 0; r < R; r++) begin
      elem = (int'(m_y) >> (r * W_Y)) & ((1 << W_Y) - 1);
      ea = sx(elem, W_Y);
      eb = sx(elem & ((1 << W_YB) - 1), W_YB);
      chk("tx_valid", ifa.tx_valid, 1);
      chk("tx_data", ifa.tx_data, ea);
      chk("tx_data_b", ifb.tx_data, eb);
      st = (r == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(0, 3));
      for (int s = 0; s < st; s++) begin
        @(posedge clk); @(negedge clk);
        chk("tx_valid_hold", ifa.tx_valid, 1);
        chk("tx_data_hold", ifa.tx_data, ea);
        chk("tx_data_b_hold", ifb.tx_data, eb);
        chk("rx_ready_send", ifa.rx_ready, 0);
      end
      ifa.tx_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      ifa.tx_ready = 1'b0;
      if (r + 1 == stop_after) return;
    end
    m_fc  = (m_fc + 1) % 256;
    m_cnt = 0;
    chk("tx_valid_done", ifa.tx_valid, 0);
    chk("frame_count", fc_a, m_fc);
    chk("frame_count_b", fc_b, m_fc);
    chk("rx_ready_back", ifa.rx_ready, 1);
    chk("busy_idle", busy_a, 0);
  endtask

  function automatic int pick_gap();
    int s;
    s = int'($urandom_range(0, 9));
    if (s < 6)  return int'($urandom_range(0, 3));
    if (s == 6) return TO - 2;
    if (s == 7) return TO - 1;
    if (s == 8) return TO + 4;
    return int'($urandom_range(4, TO - 3));
  endfunction

  task automatic run_frame();
    while (m_cnt < RXW) rx_byte(8'($urandom), pick_gap());
    issue_phase(int'($urandom_range(0, 4)));
    y_phase(int'($urandom_range(0, 3)), 16'($urandom));
    tx_phase(-1, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.rx_valid = 1'b0; ifa.rx_data = '0; ifa.mvm_ready = 1'b0;
    ifa.y_valid = 1'b0; ifa.y_data = '0; ifa.tx_ready = 1'b0;
    m_cnt = 0; m_fc = 0; m_y = '0;
    do_reset();

    // Basic frame with backpressure on the engine and TX sides
    rx_byte(8'h1B, 0);
    rx_byte(8'h35, 0);
    chk("t1_mvm_k", ifa.mvm_k, 8'h1B);
    chk("t1_mvm_x", ifa.mvm_x, 8'h35);
    issue_phase(10);
    y_phase(0, 16'hFE05);
    tx_phase(7, 0);

    // Timeout drops the first byte; the next frame starts with 0xAA
    rx_byte(8'h11, 0);
    rx_byte(8'hAA, TO + 4);
    rx_byte(8'h55, 2);
    chk("t3_mvm_k", ifa.mvm_k, 8'hAA);
    chk("t3_mvm_x", ifa.mvm_x, 8'h55);
    issue_phase(0);
    y_phase(1, 16'h7F80);
    tx_phase(0, 0);

    // Second byte lands exactly on the expiry cycle
    rx_byte(8'h3C, 0);
    rx_byte(8'hC3, TO - 2);
    chk("t4_mvm_valid", ifa.mvm_valid, 1);
    issue_phase(1);
    // Element 0 = 0x3A: 6-bit instance must sign-extend to 0xFA
    y_phase(0, 16'h053A);
    chk("t5_tx_b", ifb.tx_data, 8'hFA);
    tx_phase(2, 0);

    // Reset in SEND after the first TX byte
    rx_byte(8'h42, 1);
    rx_byte(8'h24, 3);
    issue_phase(2);
    y_phase(2, 16'h1234);
    tx_phase(0, 1);
    do_reset();

    // 256 randomized frames from reset wrap frame_count back to 0
    for (int k = 0; k < 256; k++) run_frame();
    chk("fc_wrap", fc_a, 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
